arb_requester: RTL and testbench

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_requester.sv | 131 +++++++++++++
 tb/tb_arb_requester.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// Single-channel requester for a fixed-priority arbiter: queues up to two
// burst commands and presents one request bit, counting beats while granted.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no burst in progress, waiting for a queued command
// REQ   | requesting, first beat of the head burst not yet granted
// OWN   | burst started, remaining beats issued whenever granted
// GAP   | one-cycle request drop between bursts
module arb_requester #(
  parameter int LEN_W      = 4,
  parameter int STARVE_LIM = 255
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  input  logic [LEN_W-1:0] iCmdLen,
  output logic             oRequest,
  input  logic             iGrant,
  output logic             oBeat,
  output logic             oLast,
  output logic             oBusy,
  output logic             oStarved
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_GAP} state_t;

  localparam logic [15:0] LIM = 16'(STARVE_LIM);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             load_cnt;
  logic [LEN_W-1:0] beat_cnt;
  logic [15:0]      wait_cnt;
  logic [15:0]      wait_nxt;

  // Ready is registered and only high when not full, so a push while full
  // can never sneak in on the same cycle as a pop.
  assign push       = iCmdValid & oCmdReady;
  assign pop        = oLast;
  assign fifo_empty = (count == 2'd0);
  assign count_nxt  = count + 2'(push) - 2'(pop);

  // Request comes straight from the state register; grant only gates beats.
  assign oRequest = (state == S_REQ) || (state == S_OWN);
  assign oBeat    = oRequest & iGrant;
  assign oLast    = oBeat && (beat_cnt == '0);
  assign oBusy    = (state != S_IDLE) || !fifo_empty;

  // Command storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge iClk) begin
    if (push) fifo_mem[wr_ptr] <= iCmdLen;
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      oCmdReady <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count     <= count_nxt;
      oCmdReady <= (count_nxt != 2'd2);
    end
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (!iRstN) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and beat-counter load strobe.
  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_REQ;
      S_REQ:   if (oBeat) state_nxt = oLast ? S_GAP : S_OWN;
      S_OWN:   if (oLast) state_nxt = S_GAP;
      S_GAP:   state_nxt = fifo_empty ? S_IDLE : S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    load_cnt = (state_nxt == S_REQ) && (state != S_REQ);
  end

  // Remaining-beat counter: loaded with the head length when a burst starts,
  // decremented only on granted beats so preemption just pauses it.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      beat_cnt <= '0;
    end else if (load_cnt) begin
      beat_cnt <= fifo_mem[rd_ptr];
    end else if (oBeat && (beat_cnt != '0)) begin
      beat_cnt <= beat_cnt - LEN_W'(1);
    end
  end

  // Wait-cycle count: grows while requesting without grant, saturates at
  // the limit, and clears on any beat or whenever not requesting.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!oRequest || oBeat)  wait_nxt = '0;
    else if (wait_cnt != LIM) wait_nxt = wait_cnt + 16'd1;
  end

  // Wait counter and starvation flag; the flag drops the cycle after a beat.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      wait_cnt <= '0;
      oStarved <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (oBeat)                oStarved <= 1'b0;
      else if (wait_nxt == LIM) oStarved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: expected oLast flags are queued as
// commands are pushed and popped on every observed beat; cycle-exact
// request/beat/last patterns are checked inline.
module tb_arb_requester;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_len;
  logic       request;
  logic       grant;
  logic       beat;
  logic       last;
  logic       busy;
  logic       starved;

  logic tie;
  logic gate;
  logic grant_raw;

  int n_cmp;
  int n_err;
  bit exp_last [$];
  bit g2 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  assign grant = tie ? (request & gate) : grant_raw;

  arb_requester #(.LEN_W(4), .STARVE_LIM(8)) dut (
    .iClk      (clk),
    .iRstN     (rst_n),
    .iCmdValid (cmd_valid),
    .oCmdReady (cmd_ready),
    .iCmdLen   (cmd_len),
    .oRequest  (request),
    .iGrant    (grant),
    .oBeat     (beat),
    .oLast     (last),
    .oBusy     (busy),
    .oStarved  (starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rbl(input string tag, input logic r, input logic b, input logic l);
    check({tag, "_req"},  16'(request), 16'(r));
    check({tag, "_beat"}, 16'(beat),    16'(b));
    check({tag, "_last"}, 16'(last),    16'(l));
  endtask

  task automatic expect_cmd(input int len);
    for (int i = 0; i < len; i++) exp_last.push_back(1'b0);
    exp_last.push_back(1'b1);
  endtask

  // Score the current cycle's beat, then move to just after the next edge.
  task automatic adv();
    if (beat === 1'b1) begin
      if (exp_last.size() == 0) check("unexpected_beat", 16'(beat), 16'd0);
      else                      check("sb_last", 16'(last), 16'(exp_last.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int exp_beats, input string tag);
    int nb;
    int k;
    nb = 0;
    k  = 0;
    #1;
    while (busy === 1'b1 && k < 40) begin
      if (beat === 1'b1) nb++;
      adv();
      #1;
      k++;
    end
    check({tag, "_idle"},     16'(busy), 16'd0);
    check({tag, "_beats"},    16'(nb), 16'(exp_beats));
    check({tag, "_sb_empty"}, 16'(exp_last.size()), 16'd0);
    adv();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = 4'd0;
    tie       = 1'b1;
    gate      = 1'b1;
    grant_raw = 1'b0;

    // reset state
    @(posedge clk); #1;
    adv(); adv();
    #1;
    check_rbl("rst", 1'b0, 1'b0, 1'b0);
    check("rst_busy",    16'(busy),      16'd0);
    check("rst_starved", 16'(starved),   16'd0);
    check("rst_ready",   16'(cmd_ready), 16'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 16'(cmd_ready), 16'd0);
    adv();
    #1;
    check("ready_after_release", 16'(cmd_ready), 16'd1);
    check("idle_busy", 16'(busy), 16'd0);

    // grant while not requesting is ignored
    tie = 1'b0; grant_raw = 1'b1;
    #1;
    check_rbl("stray_grant", 1'b0, 1'b0, 1'b0);
    adv();
    #1;
    check_rbl("stray_grant_next", 1'b0, 1'b0, 1'b0);
    check("stray_grant_busy", 16'(busy), 16'd0);
    tie = 1'b1; grant_raw = 1'b0;
    adv();

    // single burst, len=3, grant follows request
    cmd_valid = 1'b1; cmd_len = 4'd3; expect_cmd(3);
    #1;
    check("t1_ready", 16'(cmd_ready), 16'd1);
    check_rbl("t1_push", 1'b0, 1'b0, 1'b0);
    adv();
    cmd_valid = 1'b0;
    #1;
    check_rbl("t1_idle_wait", 1'b0, 1'b0, 1'b0);
    check("t1_busy", 16'(busy), 16'd1);
    adv();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_rbl("t1_beat", 1'b1, 1'b1, i == 3);
      adv();
    end
    #1;
    check_rbl("t1_gap", 1'b0, 1'b0, 1'b0);
    check("t1_gap_busy", 16'(busy), 16'd1);
    adv();
    #1;
    check_rbl("t1_idle", 1'b0, 1'b0, 1'b0);
    check("t1_idle_busy", 16'(busy), 16'd0);
    check("t1_sb_empty", 16'(exp_last.size()), 16'd0);
    adv();

    // preemption: grant withheld two cycles after beat 1
    cmd_valid = 1'b1; cmd_len = 4'd3; expect_cmd(3);
    adv();
    cmd_valid = 1'b0;
    adv();
    for (int i = 0; i < 6; i++) begin
      gate = g2[i];
      #1;
      check_rbl("t2_own", 1'b1, g2[i], i == 5);
      adv();
    end
    gate = 1'b1;
    #1;
    check_rbl("t2_gap", 1'b0, 1'b0, 1'b0);
    adv();
    #1;
    check("t2_idle_busy", 16'(busy), 16'd0);
    adv();

    // back-to-back len=0 then len=1
    cmd_valid = 1'b1; cmd_len = 4'd0; expect_cmd(0);
    #1;
    check("t3_ready0", 16'(cmd_ready), 16'd1);
    adv();
    cmd_len = 4'd1; expect_cmd(1);
    #1;
    check("t3_ready1", 16'(cmd_ready), 16'd1);
    adv();
    cmd_valid = 1'b0;
    #1;
    check("t3_full_ready", 16'(cmd_ready), 16'd0);
    check_rbl("t3_t", 1'b1, 1'b1, 1'b1);
    adv();
    #1;
    check_rbl("t3_gap", 1'b0, 1'b0, 1'b0);
    check("t3_gap_ready", 16'(cmd_ready), 16'd1);
    adv();
    #1;
    check_rbl("t3_t2", 1'b1, 1'b1, 1'b0);
    adv();
    #1;
    check_rbl("t3_t3", 1'b1, 1'b1, 1'b1);
    adv();
    #1;
    check_rbl("t3_gap2", 1'b0, 1'b0, 1'b0);
    adv();
    #1;
    check("t3_idle_busy", 16'(busy), 16'd0);
    adv();

    // full FIFO: third consecutive push held off
    gate = 1'b0;
    cmd_valid = 1'b1; cmd_len = 4'd1; expect_cmd(1);
    #1;
    check("t4_ready_a", 16'(cmd_ready), 16'd1);
    adv();
    cmd_len = 4'd2; expect_cmd(2);
    #1;
    check("t4_ready_b", 16'(cmd_ready), 16'd1);
    adv();
    cmd_len = 4'd0;
    #1;
    check("t4_third_held", 16'(cmd_ready), 16'd0);
    check_rbl("t4_req_nogrant", 1'b1, 1'b0, 1'b0);
    adv();
    #1;
    check("t4_still_held", 16'(cmd_ready), 16'd0);
    adv();
    cmd_valid = 1'b0; gate = 1'b1;
    drain(5, "t4");

    // starvation with limit 8
    gate = 1'b0;
    cmd_valid = 1'b1; cmd_len = 4'd1; expect_cmd(1);
    adv();
    cmd_valid = 1'b0;
    adv();
    for (int i = 0; i < 12; i++) begin
      #1;
      check("t5_starved", 16'(starved), 16'(i >= 8));
      check("t5_nobeat", 16'(beat), 16'd0);
      adv();
    end
    gate = 1'b1;
    #1;
    check_rbl("t5_grant_once", 1'b1, 1'b1, 1'b0);
    check("t5_starved_on_beat", 16'(starved), 16'd1);
    adv();
    gate = 1'b0;
    #1;
    check("t5_starved_cleared", 16'(starved), 16'd0);
    check_rbl("t5_after", 1'b1, 1'b0, 1'b0);
    adv();
    gate = 1'b1;
    drain(1, "t5");

    // reset in the middle of a len=7 burst with a second command queued
    gate = 1'b1;
    cmd_valid = 1'b1; cmd_len = 4'd7; expect_cmd(7);
    adv();
    cmd_len = 4'd2; expect_cmd(2);
    adv();
    cmd_valid = 1'b0;
    #1;
    check_rbl("t6_b0", 1'b1, 1'b1, 1'b0);
    adv();
    #1;
    check_rbl("t6_b1", 1'b1, 1'b1, 1'b0);
    adv();
    rst_n = 1'b0;
    #1;
    check_rbl("t6_b2", 1'b1, 1'b1, 1'b0);
    adv();
    rst_n = 1'b1;
    #1;
    check_rbl("t6_post_rst", 1'b0, 1'b0, 1'b0);
    check("t6_busy",    16'(busy),      16'd0);
    check("t6_starved", 16'(starved),   16'd0);
    check("t6_ready",   16'(cmd_ready), 16'd0);
    exp_last.delete();
    adv();
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t6_no_beat", 16'(beat), 16'd0);
      check("t6_no_busy", 16'(busy), 16'd0);
      adv();
    end
    #1;
    check("t6_ready_back", 16'(cmd_ready), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
